frame_scan_sequencer: RTL and testbench
=======================================

Name: frame_scan_sequencer

Overview:
- Sequences one colour-analysis pass over the captured 160x120 RGB332 frame buffer.
- Shares the buffer's single read port between VGA scan-out, which has absolute priority, and the analysis stream.
- Arms on a CPU start command and waits for the camera capture's end-of-frame. It holds capture during the scan, streams NPIX pixels with first/last markers to the colour analyzer, then reports completion through a sticky done/ack handshake.

Parameters:
- AW, 15, frame-buffer address width.
- NPIX, 19200, pixels per pass (160x120).
- BASE_ADDR, 0, address of the first pixel.
- RD_LAT, 1, frame-buffer read latency in clocks (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the CPU register: arm a pass.
- done_ack  in  1  one-cycle pulse from the CPU: clear done.
- frame_done  in  1  one-cycle pulse from capture: a frame is completely written.
- cam_hold  out  1  freezes capture writes while high.
- vga_req  in  1  VGA needs the read port this cycle.
- vga_addr  in  AW  VGA read address.
- fb_addr  out  AW  frame-buffer read address (combinational mux).
- fb_data  in  8  frame-buffer read data, RD_LAT cycles after the address.
- pix_valid  out  1  pix_data holds an analysis pixel.
- pix_data  out  8  RGB332 pixel.
- pix_first  out  1  with pix_valid: pixel index 0.
- pix_last  out  1  with pix_valid: pixel index NPIX-1.
- busy  out  1  state is ARM, SCAN or DRAIN.
- done  out  1  sticky pass-complete flag.
- stall_cnt  out  16  cycles SCAN was blocked by VGA in the last pass; saturates at 0xFFFF.

Behaviour:
- Reset: state=IDLE, idx=0, issue pipeline cleared.
- Reset values: cam_hold=0, pix_valid=0, pix_first=0, pix_last=0, pix_data=0, busy=0, done=0, stall_cnt=0.
- rst mid-pass aborts immediately; no pix_valid appears after the reset cycle.
- Port mux (combinational):
  - fb_addr = vga_addr unless state=SCAN and vga_req=0.
  - In that case fb_addr = BASE_ADDR+idx, truncated to AW bits.
- States:
  - IDLE: start -> ARM.
  - ARM: waits for frame_done. frame_done -> SCAN, cam_hold=1 and stall_cnt=0 set in the same edge. frame_done seen in IDLE/DONE is ignored.
  - SCAN, each cycle:
    - vga_req=0: read issued at idx; idx+1.
    - vga_req=1: no issue, idx holds, stall_cnt+1 (saturating).
    - Issue at idx=NPIX-1 -> DRAIN, idx=0.
  - DRAIN: RD_LAT cycles, so the last read returns. Then -> DONE with done=1 and cam_hold=0.
  - DONE: done stays 1.
    - done_ack -> IDLE, done=0.
    - start -> ARM, done=0.
    - start and done_ack in the same cycle -> start wins (ARM).
- Data path:
  - An issue tag {valid, first, last} is delayed exactly RD_LAT cycles.
  - pix_data is fb_data captured in that cycle.
  - pix_valid rises RD_LAT+1 clocks after the issuing edge, i.e. registered output.
  - Exactly NPIX pix_valid pulses per pass, in address order, with gaps only where VGA stalled.
- start while busy=1 is ignored.
- done_ack outside DONE is ignored.
- NPIX=1: the single pixel carries both pix_first and pix_last.
- cam_hold is high from the frame_done edge in ARM until the DRAIN->DONE edge. It is never high in IDLE or DONE.
- VGA reads are never delayed or blocked by this block.

Test Plan:
- Basic pass (NPIX=8, BASE_ADDR=0x10, RD_LAT=1, vga_req=0): start, frame_done 5 cycles later -> addresses 0x10..0x17 on 8 consecutive cycles. pix_valid pulses carry memory values 0..7; pix_first on value 0, pix_last on value 7. done=1 two cycles after the last issue; stall_cnt=0; cam_hold high only during the scan.
- VGA contention (NPIX=8): vga_req=1 on scan cycles 2,3,6 -> fb_addr=vga_addr on those cycles. Still 8 ordered pixels, scan takes 11 cycles, stall_cnt=3.
- Handshake: in DONE, assert done_ack -> done=0, IDLE. Then start and done_ack together in DONE -> ARM, busy=1.
- Ignored events: frame_done in IDLE -> stays IDLE. start during SCAN -> pass unaffected, no re-arm.
- Reset mid-scan after 4 pixels -> all outputs 0 next cycle, no further pix_valid. A fresh start+frame_done restarts from BASE_ADDR.
- Latency sweep: RD_LAT=3, NPIX=1 -> single pixel with pix_first=pix_last=1, arriving 4 clocks after issue; done one cycle after DRAIN.

Source files
------------

// File: rtl/frame_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : frame_scan_sequencer
// Brief   : One analysis pass over the frame buffer, sharing its read port with VGA.
// Revision: 1.0 - initial release
// ============================================================================
module frame_scan_sequencer #(
    parameter int AW        = 15,
    parameter int NPIX      = 19200,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          done_ack,
    input  logic          frame_done,
    output logic          cam_hold,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_data,
    output logic          pix_valid,
    output logic [7:0]    pix_data,
    output logic          pix_first,
    output logic          pix_last,
    output logic          busy,
    output logic          done,
    output logic [15:0]   stall_cnt
);

    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IW-1:0] c_last_idx  = IW'(NPIX - 1);
    localparam logic [AW-1:0] c_base      = AW'(BASE_ADDR);
    localparam logic [DW-1:0] c_drain_end = DW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_drain;
    // Issue tag {valid, first, last}, aligned with fb_data at the last stage
    logic [2:0]    r_tag [RD_LAT];

    logic          w_issue;

    assign w_issue = (r_state == S_SCAN) && !vga_req;
    assign fb_addr = w_issue ? (c_base + AW'(r_idx)) : vga_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_drain   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_tag[k] <= '0;
            end
            cam_hold  <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            r_tag[0] <= {w_issue, w_issue && (r_idx == '0), w_issue && (r_idx == c_last_idx)};
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            pix_valid <= r_tag[RD_LAT-1][2];
            pix_first <= r_tag[RD_LAT-1][2] & r_tag[RD_LAT-1][1];
            pix_last  <= r_tag[RD_LAT-1][2] & r_tag[RD_LAT-1][0];
            if (r_tag[RD_LAT-1][2]) begin
                pix_data <= fb_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARM;
                        busy    <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (frame_done) begin
                        r_state   <= S_SCAN;
                        r_idx     <= '0;
                        cam_hold  <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    if (vga_req) begin
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end else if (r_idx == c_last_idx) begin
                        r_state <= S_DRAIN;
                        r_idx   <= '0;
                        r_drain <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == c_drain_end) begin
                        r_state  <= S_DONE;
                        done     <= 1'b1;
                        cam_hold <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                S_DONE: begin
                    // start takes precedence over a simultaneous acknowledge
                    if (start) begin
                        r_state <= S_ARM;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                    end else if (done_ack) begin
                        r_state <= S_IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_frame_scan_sequencer
// Brief   : Directed vector table, corner sequences and randomized model check.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_scan_sequencer;

    localparam int AW     = 15;
    localparam int A_N    = 8;
    localparam int A_BASE = 16;
    localparam int A_LAT  = 1;
    localparam int B_N    = 1;
    localparam int B_BASE = 5;
    localparam int B_LAT  = 3;
    localparam int VA     = 'h0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_start = 0, a_ack = 0, a_fd = 0, a_vreq = 0;
    logic [AW-1:0] a_vaddr = AW'(VA);
    logic [AW-1:0] a_fb_addr, a_p1;
    logic [7:0] a_fb_data, a_pd;
    logic a_hold, a_pv, a_pf, a_pl, a_busy, a_done;
    logic [15:0] a_stall;

    logic b_start = 0, b_ack = 0, b_fd = 0, b_vreq = 0;
    logic [AW-1:0] b_vaddr = 15'h7000;
    logic [AW-1:0] b_fb_addr, b_p1, b_p2, b_p3;
    logic [7:0] b_fb_data, b_pd;
    logic b_hold, b_pv, b_pf, b_pl, b_busy, b_done;
    logic [15:0] b_stall;

    frame_scan_sequencer #(.AW(AW), .NPIX(A_N), .BASE_ADDR(A_BASE), .RD_LAT(A_LAT)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .done_ack(a_ack), .frame_done(a_fd),
        .cam_hold(a_hold), .vga_req(a_vreq), .vga_addr(a_vaddr), .fb_addr(a_fb_addr),
        .fb_data(a_fb_data), .pix_valid(a_pv), .pix_data(a_pd), .pix_first(a_pf),
        .pix_last(a_pl), .busy(a_busy), .done(a_done), .stall_cnt(a_stall)
    );

    frame_scan_sequencer #(.AW(AW), .NPIX(B_N), .BASE_ADDR(B_BASE), .RD_LAT(B_LAT)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .done_ack(b_ack), .frame_done(b_fd),
        .cam_hold(b_hold), .vga_req(b_vreq), .vga_addr(b_vaddr), .fb_addr(b_fb_addr),
        .fb_data(b_fb_data), .pix_valid(b_pv), .pix_data(b_pd), .pix_first(b_pf),
        .pix_last(b_pl), .busy(b_busy), .done(b_done), .stall_cnt(b_stall)
    );

    // Frame-buffer memory: content at address a is (a - 0x10), so 0x10.. reads 0,1,2..
    function automatic logic [7:0] mem8(input logic [AW-1:0] a);
        return 8'(a - 15'h10);
    endfunction

    always @(posedge clk) begin
        a_p1 <= a_fb_addr;
        b_p1 <= b_fb_addr;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign a_fb_data = mem8(a_p1);
    assign b_fb_data = mem8(b_p3);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drv_a(input logic st, input logic fd, input logic vr, input logic ak);
        @(posedge clk);
        #1;
        a_start = st;
        a_fd    = fd;
        a_vreq  = vr;
        a_ack   = ak;
    endtask

    typedef struct {
        logic st, fd, vr, ak;
        logic [AW-1:0] addr;
        logic pv;
        logic [7:0] pd;
        logic pf, pl, by, dn, hd;
        logic [15:0] sl;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int st, input int fd, input int vr, input int ak,
                                input int ad, input int pv, input int pd, input int pf,
                                input int pl, input int by, input int dn, input int hd,
                                input int sl);
        vec_t v;
        v.st = st[0]; v.fd = fd[0]; v.vr = vr[0]; v.ak = ak[0];
        v.addr = AW'(ad); v.pv = pv[0]; v.pd = 8'(pd); v.pf = pf[0]; v.pl = pl[0];
        v.by = by[0]; v.dn = dn[0]; v.hd = hd[0]; v.sl = 16'(sl);
        tbl.push_back(v);
    endfunction

    typedef struct {
        int due;
        logic [7:0] d;
        logic f, l;
    } pexp_t;

    initial begin
        int cnt, iss, pvc, dnc, npv;
        logic pvf, pvl;
        logic [7:0] pvd;
        int ph, k, stalls, done_due, passes;
        pexp_t q[$];
        pexp_t e;
        logic [AW-1:0] exp_addr;

        // cycle-by-cycle table: basic pass, handshake, ignored events, contention
        add(1,0,0,0, VA, 0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,0, VA, 0,0,0,0, 1,0,0,0);
        add(0,1,0,0, VA,    0,0,0,0, 1,0,0,0);
        add(0,0,0,0, 'h10,  0,0,0,0, 1,0,1,0);
        add(0,0,0,0, 'h11,  0,0,0,0, 1,0,1,0);
        for (int i = 0; i < 6; i++) add(0,0,0,0, 'h12+i, 1,i,(i==0 ? 1 : 0),0, 1,0,1,0);
        add(0,0,0,0, VA,    1,6,0,0, 1,0,1,0);
        add(0,0,0,0, VA,    1,7,0,1, 0,1,0,0);
        add(0,0,0,1, VA,    0,0,0,0, 0,1,0,0);
        add(0,1,0,0, VA,    0,0,0,0, 0,0,0,0);
        add(1,0,0,0, VA,    0,0,0,0, 0,0,0,0);
        add(0,1,0,0, VA,    0,0,0,0, 1,0,0,0);
        add(0,0,0,0, 'h10,  0,0,0,0, 1,0,1,0);
        add(0,0,0,0, 'h11,  0,0,0,0, 1,0,1,0);
        add(0,0,1,0, VA,    1,0,1,0, 1,0,1,0);
        add(0,0,1,0, VA,    1,1,0,0, 1,0,1,1);
        add(0,0,0,0, 'h12,  0,0,0,0, 1,0,1,2);
        add(1,0,0,0, 'h13,  0,0,0,0, 1,0,1,2);
        add(0,0,1,0, VA,    1,2,0,0, 1,0,1,2);
        add(0,0,0,0, 'h14,  1,3,0,0, 1,0,1,3);
        add(0,0,0,0, 'h15,  0,0,0,0, 1,0,1,3);
        add(0,0,0,0, 'h16,  1,4,0,0, 1,0,1,3);
        add(0,0,0,0, 'h17,  1,5,0,0, 1,0,1,3);
        add(0,0,0,0, VA,    1,6,0,0, 1,0,1,3);
        add(1,0,0,1, VA,    1,7,0,1, 0,1,0,3);
        add(0,0,0,0, VA,    0,0,0,0, 1,0,0,3);

        @(posedge clk);
        @(negedge clk);
        chk("reset A outputs", {a_pv, a_pf, a_pl, a_busy, a_done, a_hold, a_pd, a_stall}, 0);
        chk("reset B outputs", {b_pv, b_pf, b_pl, b_busy, b_done, b_hold, b_pd, b_stall}, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            drv_a(tbl[r].st, tbl[r].fd, tbl[r].vr, tbl[r].ak);
            rst = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d fb_addr", r), a_fb_addr, tbl[r].addr);
            chk($sformatf("tbl%0d pix_valid", r), a_pv, tbl[r].pv);
            if (tbl[r].pv) chk($sformatf("tbl%0d pix_data", r), a_pd, tbl[r].pd);
            chk($sformatf("tbl%0d first/last", r), {a_pf, a_pl}, {tbl[r].pf, tbl[r].pl});
            chk($sformatf("tbl%0d busy/done/hold", r), {a_busy, a_done, a_hold},
                {tbl[r].by, tbl[r].dn, tbl[r].hd});
            chk($sformatf("tbl%0d stall_cnt", r), a_stall, tbl[r].sl);
        end

        // reset mid-scan after 4 delivered pixels (A is armed here)
        drv_a(0,1,0,0);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 4; n++) begin
            drv_a(0,0,0,0);
            @(negedge clk);
            if (a_pv) cnt++;
        end
        chk("pixels before reset", cnt, 4);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid-scan reset outputs", {a_pv, a_pf, a_pl, a_busy, a_done, a_hold, a_pd, a_stall}, 0);
        chk("mid-scan reset fb_addr", a_fb_addr, AW'(VA));
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            drv_a(0,0,0,0);
            @(negedge clk);
            if (a_pv) cnt++;
        end
        chk("no pixels after reset", cnt, 0);
        drv_a(1,0,0,0);
        drv_a(0,1,0,0);
        drv_a(0,0,0,0);
        @(negedge clk);
        chk("restart addr", a_fb_addr, AW'(A_BASE));
        chk("restart cam_hold", a_hold, 1);

        // latency sweep: RD_LAT=3, single pixel
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0; b_fd = 1'b1;
        iss = -1; pvc = -1; dnc = -1; npv = 0; pvf = 0; pvl = 0; pvd = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1; b_fd = 1'b0;
            @(negedge clk);
            if (b_fb_addr == AW'(B_BASE) && iss < 0) iss = n;
            if (b_pv) begin
                npv++;
                if (pvc < 0) begin pvc = n; pvf = b_pf; pvl = b_pl; pvd = b_pd; end
            end
            if (b_done && dnc < 0) dnc = n;
            if (iss >= 0 && n == iss + 2) chk("B hold in drain", {b_hold, b_busy}, 2'b11);
        end
        chk("B issue cycle", iss, 0);
        chk("B pix latency", pvc - iss, 4);
        chk("B done latency", dnc - iss, 4);
        chk("B pix count", npv, 1);
        chk("B first/last", {pvf, pvl}, 2'b11);
        chk("B pix data", pvd, mem8(AW'(B_BASE)));
        chk("B final", {b_done, b_busy, b_hold, b_stall}, {3'b100, 16'd0});

        // randomized traffic against a pass-level reference model
        @(posedge clk); #1; rst = 1'b1;
        a_start = 0; a_fd = 0; a_vreq = 0; a_ack = 0;
        @(posedge clk); #1; rst = 1'b0;
        ph = 0; k = 0; stalls = 0; done_due = -1; passes = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            a_start = ($urandom_range(0, 9) == 0);
            a_ack   = ($urandom_range(0, 9) == 0);
            a_fd    = ($urandom_range(0, 6) == 0);
            a_vreq  = ($urandom_range(0, 2) == 0);
            a_vaddr = AW'($urandom);
            @(negedge clk);
            if (ph == 3 && c == done_due) begin
                ph = 4;
                passes++;
                chk("rnd stall_cnt", a_stall, 16'(stalls));
            end
            exp_addr = (ph == 2 && !a_vreq) ? AW'(A_BASE + k) : a_vaddr;
            chk("rnd fb_addr", a_fb_addr, exp_addr);
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                chk("rnd pix_valid", a_pv, 1);
                chk("rnd pix", {a_pd, a_pf, a_pl}, {e.d, e.f, e.l});
            end else begin
                chk("rnd pix_valid", a_pv, 0);
            end
            chk("rnd busy/done/hold", {a_busy, a_done, a_hold},
                {(ph >= 1 && ph <= 3), (ph == 4), (ph == 2 || ph == 3)});
            case (ph)
                0: if (a_start) ph = 1;
                1: if (a_fd) begin ph = 2; k = 0; stalls = 0; end
                2: begin
                    if (a_vreq) begin
                        stalls++;
                    end else begin
                        e.due = c + A_LAT + 1;
                        e.d = mem8(AW'(A_BASE + k));
                        e.f = (k == 0);
                        e.l = (k == A_N - 1);
                        q.push_back(e);
                        k++;
                        if (k == A_N) begin ph = 3; done_due = c + A_LAT + 1; end
                    end
                end
                4: begin
                    if (a_start) ph = 1;
                    else if (a_ack) ph = 0;
                end
                default: ;
            endcase
        end
        chk("rnd passes completed", (passes >= 3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
